tff_stream_decoder: RTL and testbench
=====================================

Name: tff_stream_decoder

Overview:
- Receive-side partner of the D-to-T conversion path. A toggle-encoded serial stream arrives one bit per strobe; a 1 on t_in means "invert the line level" and a 0 means "hold it".
- Internally a T flip-flop built from a D register (q <= q ^ t) rebuilds the level stream. The rebuilt levels are deserialised into a WIDTH-bit word, checked against a trailing even-parity bit, and delivered with a one-cycle valid pulse.
- Sits between a serial toggle-line front end and word-oriented logic.

Parameters:
- WIDTH, 8, data bits per frame (legal range 2..32).
- CNT_W, 5, bit-counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous reset, active-low (0 = reset).
- start  input  1  one-cycle frame-start pulse; sampled in IDLE only.
- t_valid  input  1  qualifies t_in for this cycle.
- t_in  input  1  toggle bit: 1 = invert level, 0 = hold level.
- level_q  output  1  current rebuilt line level (the T flip-flop state).
- busy  output  1  high while in SHIFT or PARITY.
- data  output  WIDTH  last completed word; holds until the next frame completes.
- data_valid  output  1  one-cycle pulse when data and parity_err update.
- parity_err  output  1  1 when the last frame failed even parity; holds with data.

Behaviour:
- Reset (rst=0, async): state=IDLE, level_q=0, shift register=0, counter=0, data=0, data_valid=0, parity_err=0, busy=0.
- Rebuilt bit: b = level_q ^ t_in. On every accepted bit (t_valid=1 in SHIFT or PARITY), level_q <= b.
- IDLE:
  - start=1 -> SHIFT; level_q<=0 (reference level); counter<=0; shift register<=0.
  - t_valid in IDLE without start is ignored; level_q is unchanged.
  - start and t_valid in the same cycle: start wins; that t_in is discarded.
- SHIFT:
  - On t_valid: shift register <= {b, sr[WIDTH-1:1]} (LSB first); counter++.
  - When the bit with counter==WIDTH-1 is accepted -> PARITY.
  - t_valid=0: all state holds; gaps of any length are legal.
- PARITY:
  - On t_valid: pbit = b; parity_err <= (^sr) ^ pbit; data <= sr; data_valid <= 1; -> IDLE.
  - Even parity is defined as total ones across data plus pbit being even.
- data_valid is registered: high exactly the one cycle after the edge that accepted the parity bit; otherwise 0.
- Latency: after start, WIDTH+1 accepted bits; data_valid follows the final accepted bit by 1 cycle.
- busy is 1 in SHIFT and PARITY, 0 in IDLE. It falls in the same cycle that data_valid rises.
- start while busy is ignored; the frame in progress continues unaffected.
- A new start may be issued in the cycle data_valid is high (the FSM is already in IDLE).
- level_q is not cleared at end of frame; it holds until the next start or reset.
- Reset mid-frame: immediate return to IDLE; a partial word is never presented and data is cleared to 0.

Test Plan:
1. Reset: hold rst=0 for 2 cycles -> all outputs 0, busy=0; release rst -> outputs stay 0 with no stimulus.
2. Nominal frame, WIDTH=8: start, then t_in = 1,1,1,1,0,1,1,1 (data) and 1 (parity) with t_valid continuous -> one cycle later data=8'hA5, data_valid=1 for 1 cycle, parity_err=0, level_q=0; busy was high for 9 cycles.
3. Parity error: same frame, parity t_in=0 -> data=8'hA5, parity_err=1, data_valid pulse.
4. Strobe gaps: frame 2 sent with t_valid=0 inserted for 3 cycles between every bit -> identical result; busy stays high through the gaps.
5. Ignored events:
   - start pulsed at bit 4 of a frame -> no restart, correct word delivered.
   - t_valid pulses in IDLE -> level_q unchanged, no data_valid.
   - start and t_valid in the same cycle -> that t_in is discarded.
6. Reset mid-frame: assert rst=0 after bit 5 -> busy=0 and data=0 at once, and no data_valid. Then a full frame of all-zero t_in (parity 0) -> data=8'h00, parity_err=0.

Source files
------------

// File: rtl/tff_stream_decoder.sv
// -----------------------------------------------------------------------------
// tff_stream_decoder
//   Receive side of a toggle-encoded serial link. Each accepted t_in bit says
//   whether the line level inverts (1) or holds (0). A T flip-flop built from a
//   D register rebuilds the level stream. Rebuilt levels are deserialised LSB
//   first into a WIDTH-bit word. A trailing even-parity bit is checked, and the
//   word is delivered with a one-cycle data_valid pulse.
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   asynchronous reset, active-low
//   start      in   frame-start pulse, honoured only while idle
//   t_valid    in   qualifies t_in
//   t_in       in   toggle bit (1 = invert level, 0 = hold)
//   level_q    out  current rebuilt line level (T flip-flop state)
//   busy       out  high while a frame is being received
//   data       out  last completed word, held until the next frame completes
//   data_valid out  one-cycle pulse when data / parity_err update
//   parity_err out  1 when the last frame failed even parity
// -----------------------------------------------------------------------------
module tff_stream_decoder #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             t_valid,
  input  logic             t_in,
  output logic             level_q,
  output logic             busy,
  output logic [WIDTH-1:0] data,
  output logic             data_valid,
  output logic             parity_err
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_PARITY = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_t           r_state;
  logic             r_level;
  logic [WIDTH-1:0] r_sr;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_data;
  logic             r_data_valid;
  logic             r_parity_err;

  // Rebuilt level for the bit on the wire this cycle: the T flip-flop's next state.
  logic w_bit;
  assign w_bit = r_level ^ t_in;

  // NOTE: all state below is updated with non-blocking assignments so every
  // register samples the pre-edge values of its neighbours (w_bit and r_sr
  // must see the old level / old shift contents in the same edge).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= ST_IDLE;
      r_level      <= 1'b0;
      r_sr         <= '0;
      r_cnt        <= '0;
      r_data       <= '0;
      r_data_valid <= 1'b0;
      r_parity_err <= 1'b0;
    end else begin
      r_data_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          // A strobe arriving with start is discarded; the frame's reference
          // level is 0 regardless of what the line held before.
          if (start) begin
            r_state <= ST_SHIFT;
            r_level <= 1'b0;
            r_cnt   <= '0;
            r_sr    <= '0;
          end
        end
        ST_SHIFT: begin
          if (t_valid) begin
            r_level <= w_bit;
            r_sr    <= {w_bit, r_sr[WIDTH-1:1]};
            r_cnt   <= r_cnt + 1'b1;
            if (r_cnt == LAST_BIT) begin
              r_state <= ST_PARITY;
            end
          end
        end
        ST_PARITY: begin
          if (t_valid) begin
            r_level      <= w_bit;
            // Even parity: ones in data plus the parity bit must be even.
            r_parity_err <= (^r_sr) ^ w_bit;
            r_data       <= r_sr;
            r_data_valid <= 1'b1;
            r_state      <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign level_q    = r_level;
  assign busy       = (r_state != ST_IDLE);
  assign data       = r_data;
  assign data_valid = r_data_valid;
  assign parity_err = r_parity_err;

endmodule

// File: tb/tb_tff_stream_decoder.sv
// -----------------------------------------------------------------------------
// tb_tff_stream_decoder
//   Self-checking bench for tff_stream_decoder (WIDTH = 8). Directed frames come
//   from a vector table; random frames are produced by encoding a random word
//   into toggles and compared against that word and its parity.
// -----------------------------------------------------------------------------
module tb_tff_stream_decoder;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic         t_valid = 1'b0;
  logic         t_in = 1'b0;
  logic         level_q;
  logic         busy;
  logic [W-1:0] data;
  logic         data_valid;
  logic         parity_err;

  int tests = 0;
  int fails = 0;
  int dv_count = 0;

  tff_stream_decoder #(.WIDTH(W), .CNT_W(5)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .t_valid   (t_valid),
    .t_in      (t_in),
    .level_q   (level_q),
    .busy      (busy),
    .data      (data),
    .data_valid(data_valid),
    .parity_err(parity_err)
  );

  always #5 clk = ~clk;

  // Counts data_valid pulses; each pulse lasts one cycle, so it is seen once.
  always @(posedge clk) begin
    if (data_valid === 1'b1) dv_count++;
  end

  typedef struct {
    string        name;
    logic [W:0]   tbits;      // bit i is the i-th toggle sent; bit W is the parity toggle
    int           gap;        // idle strobe cycles between bits
    int           restart_at; // bit index where a stray start is pulsed (-1 = none)
    bit           start_tv;   // assert t_valid together with start
    logic [W-1:0] exp_data;
    logic         exp_err;
    logic         exp_level;
  } vec_t;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Sends one frame starting at a negedge and checks the delivered result.
  task automatic run_frame(input vec_t v);
    int busy_bad;
    int dv_before;
    busy_bad  = 0;
    dv_before = dv_count;
    @(negedge clk);
    start   = 1'b1;
    t_valid = v.start_tv;
    t_in    = 1'b1;
    @(negedge clk);
    start   = 1'b0;
    t_valid = 1'b0;
    for (int i = 0; i <= W; i++) begin
      if (busy !== 1'b1) busy_bad++;
      t_valid = 1'b1;
      t_in    = v.tbits[i];
      start   = (i == v.restart_at);
      @(negedge clk);
      t_valid = 1'b0;
      start   = 1'b0;
      if (i < W) begin
        for (int g = 0; g < v.gap; g++) begin
          if (busy !== 1'b1) busy_bad++;
          @(negedge clk);
        end
      end
    end
    check({v.name, " busy during frame"}, busy_bad, 0);
    check({v.name, " data_valid"}, data_valid, 1);
    check({v.name, " data"}, data, v.exp_data);
    check({v.name, " parity_err"}, parity_err, v.exp_err);
    check({v.name, " level_q"}, level_q, v.exp_level);
    check({v.name, " busy after"}, busy, 0);
    @(negedge clk);
    check({v.name, " data_valid pulse width"}, data_valid, 0);
    check({v.name, " pulse count"}, dv_count - dv_before, 1);
  endtask

  // Reference encoder: turn a data word and parity bit into the toggle stream.
  function automatic logic [W:0] encode(input logic [W-1:0] word, input logic pbit);
    logic [W:0] t;
    logic       lvl;
    lvl = 1'b0;
    for (int i = 0; i < W; i++) begin
      t[i] = word[i] ^ lvl;
      lvl  = word[i];
    end
    t[W] = pbit ^ lvl;
    return t;
  endfunction

  vec_t vecs[$];

  initial begin
    vec_t v;
    logic lvl_snap;
    int   dv_snap;

    vecs.push_back('{"nominal",     9'h1EF, 0, -1, 1'b0, 8'hA5, 1'b0, 1'b0});
    vecs.push_back('{"parity_err",  9'h0EF, 0, -1, 1'b0, 8'hA5, 1'b1, 1'b1});
    vecs.push_back('{"gaps",        9'h1EF, 3, -1, 1'b0, 8'hA5, 1'b0, 1'b0});
    vecs.push_back('{"start_mid",   9'h1EF, 0,  4, 1'b0, 8'hA5, 1'b0, 1'b0});
    vecs.push_back('{"start_tv",    9'h1EF, 0, -1, 1'b1, 8'hA5, 1'b0, 1'b0});
    vecs.push_back('{"all_toggle",  9'h1FF, 1, -1, 1'b0, 8'h55, 1'b1, 1'b1});

    // Reset held for two cycles, then released with no stimulus.
    repeat (2) @(negedge clk);
    check("reset busy", busy, 0);
    check("reset data", data, 0);
    check("reset data_valid", data_valid, 0);
    check("reset parity_err", parity_err, 0);
    check("reset level_q", level_q, 0);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("idle busy", busy, 0);
    check("idle data", data, 0);
    check("idle data_valid", data_valid, 0);

    foreach (vecs[k]) run_frame(vecs[k]);

    // Strobes in IDLE do not move the level or produce output.
    lvl_snap = level_q;
    dv_snap  = dv_count;
    for (int i = 0; i < 4; i++) begin
      t_valid = 1'b1;
      t_in    = 1'b1;
      @(negedge clk);
    end
    t_valid = 1'b0;
    @(negedge clk);
    check("idle strobe level_q", level_q, lvl_snap);
    check("idle strobe no dv", dv_count - dv_snap, 0);
    check("idle strobe busy", busy, 0);

    // Reset mid-frame after five bits: outputs cleared at once, no pulse.
    dv_snap = dv_count;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      t_valid = 1'b1;
      t_in    = 1'b1;
      @(negedge clk);
    end
    t_valid = 1'b0;
    check("pre-reset busy", busy, 1);
    rst = 1'b0;
    #1;
    check("midreset busy", busy, 0);
    check("midreset data", data, 0);
    check("midreset level_q", level_q, 0);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("midreset no dv", dv_count - dv_snap, 0);
    v = '{"zeros", 9'h000, 0, -1, 1'b0, 8'h00, 1'b0, 1'b0};
    run_frame(v);

    // Randomised frames: random word and parity bit, random gaps.
    for (int n = 0; n < 40; n++) begin
      logic [W-1:0] word;
      logic         pbit;
      word = W'($urandom);
      pbit = 1'($urandom);
      v.name       = $sformatf("rand%0d", n);
      v.tbits      = encode(word, pbit);
      v.gap        = int'($urandom_range(0, 2));
      v.restart_at = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, W)) : -1;
      v.start_tv   = 1'($urandom);
      v.exp_data   = word;
      v.exp_err    = 1'(($countones(word) + int'(pbit)) % 2);
      v.exp_level  = pbit;
      run_frame(v);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
